// File: rtl/usb_apb_pkg.sv
// Shared types and constants for the USB register-bus APB3 initiator.
package usb_apb_pkg;

  localparam int APB_ADDR_W = 40;
  localparam int APB_DATA_W = 32;

  // Read data returned when a transfer is abandoned for lack of pready.
  localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_t;

endpackage

// File: rtl/usb_apb_master.sv
// APB3 initiator: one valid/ready command becomes one SETUP/ACCESS transfer, answered on a response stream.
// Optional ACCESS timeout is compiled in with `define USB_APB_MASTER_TIMEOUT_EN.
module usb_apb_master
  import usb_apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("usb_apb_master: TIMEOUT_CYCLES must be at least 2");
  end

  apb_mst_state_t    r_state;
  apb_mst_state_t    w_next_state;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;

  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_done   = (r_state == ACCESS) & pready;

`ifdef USB_APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == ACCESS) && !pready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // A completer answering in the final allowed cycle still wins over the abort.
  assign w_abort = (r_state == ACCESS) && !pready &&
                   (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state is defaulted before the case so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = SETUP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Every bus-facing output is a flop driven from the next state, so nothing on cmd_* reaches p* in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
      r_psel      <= (w_next_state == SETUP) || (w_next_state == ACCESS);
      r_penable   <= (w_next_state == ACCESS);
      r_rsp_valid <= (w_next_state == RESP);

      if (w_accept) begin
        r_paddr  <= cmd_addr & ~ADDR_W'(3);
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
      end

      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
        r_rsp_err   <= pslverr;
      end else if (w_abort) begin
        r_rsp_rdata <= DATA_W'(APB_TIMEOUT_RDATA);
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_usb_apb_master.sv
// Directed and randomized bench for usb_apb_master against a simple APB register-file completer model.
// Timeout expectations follow `define USB_APB_MASTER_TIMEOUT_EN when it is set for the build.
module tb_usb_apb_master;

  localparam int ADDR_W = 40;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int n_checks = 0;
  int n_errors = 0;

  // Completer register file: 16 words, word index taken from the aligned byte address.
  logic [31:0] mem [16];

  usb_apb_master #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .psel     (psel),
    .penable  (penable),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_psel"},      psel,      1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  // One complete command: issued at a negedge, checked every cycle, returns at a negedge in IDLE.
  task automatic do_txn(input bit wr, input logic [39:0] addr, input logic [31:0] wd,
                        input int waits, input bit err, input int hold, input bit keep_valid);
    logic [39:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    int          idx;
    exp_addr = addr - (addr % 4);
    idx      = int'((exp_addr / 4) % 16);
    exp_wd   = wr ? wd : 32'h0;
    exp_rd   = wr ? 32'h0 : mem[idx];

    check("cmd_ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;

    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
    check("setup_psel",    psel,      1'b1);
    check("setup_penable", penable,   1'b0);
    check("setup_paddr",   paddr,     exp_addr);
    check("setup_pwrite",  pwrite,    wr);
    check("setup_pwdata",  pwdata,    exp_wd);
    check("setup_busy",    busy,      1'b1);
    check("setup_cmd_rdy", cmd_ready, 1'b0);

    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      check("access_psel",    psel,      1'b1);
      check("access_penable", penable,   1'b1);
      check("access_paddr",   paddr,     exp_addr);
      check("access_pwdata",  pwdata,    exp_wd);
      check("access_pwrite",  pwrite,    wr);
      check("access_rsp_vld", rsp_valid, 1'b0);
      check("access_cmd_rdy", cmd_ready, 1'b0);
      pready    = (c == waits);
      pslverr   = (c == waits) ? err : 1'($urandom_range(0, 1));
      prdata    = wr ? $urandom : mem[idx];
      rsp_ready = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    pready  = 1'b0;
    pslverr = 1'b0;
    for (int k = 0; k <= hold; k++) begin
      check("resp_valid",   rsp_valid, 1'b1);
      check("resp_rdata",   rsp_rdata, exp_rd);
      check("resp_err",     rsp_err,   err);
      check("resp_psel",    psel,      1'b0);
      check("resp_penable", penable,   1'b0);
      check("resp_cmd_rdy", cmd_ready, 1'b0);
      rsp_ready = (k == hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_idle("post_txn");
    check("post_paddr_held", paddr, exp_addr);

    if (wr && !err) mem[idx] = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_psel",      psel,      1'b0);
    check("rst_penable",   penable,   1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_paddr",     paddr,     40'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1'b1);

    // Directed: plain write, read of a status word, wait states with error, back-pressure.
    do_txn(1'b1, 40'h000, 32'h1234_5678, 0, 1'b0, 0, 1'b0);
    mem[0] = 32'h0000_0001;
    do_txn(1'b0, 40'h000, 32'h0, 0, 1'b0, 0, 1'b0);
    do_txn(1'b1, 40'h010, 32'hCAFE_F00D, 5, 1'b1, 0, 1'b0);
    do_txn(1'b0, 40'h010, 32'h0, 5, 1'b1, 0, 1'b0);
    do_txn(1'b1, 40'h024, 32'hA5A5_0F0F, 1, 1'b0, 3, 1'b1);
    do_txn(1'b0, 40'h024, 32'h0, 0, 1'b0, 3, 1'b1);

    // Randomized traffic against the register-file model.
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom_range(0, 1)), 40'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    // Transfer whose completer never answers.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 40'h008;
    @(negedge clk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
`ifdef USB_APB_MASTER_TIMEOUT_EN
    for (int c = 0; c < TO_CYC; c++) begin
      @(negedge clk);
      check("to_penable",   penable,   1'b1);
      check("to_rsp_valid", rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("to_rsp_valid_abort", rsp_valid, 1'b1);
    check("to_rsp_err",         rsp_err,   1'b1);
    check("to_rsp_rdata",       rsp_rdata, 32'hFFFF_FFFF);
    check("to_psel",            psel,      1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_idle("to_done");

    // Start another transfer so the reset below lands in ACCESS.
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", penable, 1'b1);
`else
    repeat (TO_CYC * 3) @(negedge clk);
    check("hang_busy",      busy,      1'b1);
    check("hang_penable",   penable,   1'b1);
    check("hang_rsp_valid", rsp_valid, 1'b0);
`endif

    // Asynchronous reset in the middle of ACCESS, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("arst_psel",      psel,      1'b0);
    check("arst_penable",   penable,   1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_busy",      busy,      1'b0);
    check("arst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("arst_rel_cmd_ready", cmd_ready, 1'b1);

    do_txn(1'b1, 40'h7, 32'h0BAD_BEEF, 2, 1'b0, 1, 1'b0);
    do_txn(1'b0, 40'h7, 32'h0, 0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
